// File: rtl/bip_system_if.sv
// Load, control and observation signals of the BIP processor system.
interface bip_system_if #(
    parameter int unsigned NBITS_O   = 11,
    parameter int unsigned NBITS_D   = 16,
    parameter int unsigned NBITS_CNT = 32
);
    logic                 i_load_en;
    logic [NBITS_O-1:0]   i_load_addr;
    logic [NBITS_D-1:0]   i_load_data;
    logic                 i_start;
    logic                 i_mode;
    logic                 i_step;
    logic [NBITS_O-1:0]   o_pc;
    logic [NBITS_D-1:0]   o_acc;
    logic                 o_enable;
    logic                 o_halt;
    logic [NBITS_CNT-1:0] o_cycles;

    // Driver side: board top, UART debug front end or bench
    modport master (
        output i_load_en, i_load_addr, i_load_data, i_start, i_mode, i_step,
        input  o_pc, o_acc, o_enable, o_halt, o_cycles
    );

    // Processor side
    modport slave (
        input  i_load_en, i_load_addr, i_load_data, i_start, i_mode, i_step,
        output o_pc, o_acc, o_enable, o_halt, o_cycles
    );
endinterface

// File: rtl/bip_system.sv
// Single-cycle accumulator BIP processor with loadable program memory,
// data memory, run/step execution, halt detection and instruction counter.
module bip_system #(
    parameter int unsigned NBITS_O   = 11,
    parameter int unsigned OPCODE    = 5,
    parameter int unsigned NBITS_D   = 16,
    parameter int unsigned PM_CELDAS = 512,
    parameter int unsigned DM_CELDAS = 512,
    parameter int unsigned NBITS_CNT = 32
) (
    input  logic         i_clock,
    input  logic         i_reset,
    bip_system_if.slave  bus
);
    localparam int unsigned PM_AW = (PM_CELDAS > 1) ? $clog2(PM_CELDAS) : 1;
    localparam int unsigned DM_AW = (DM_CELDAS > 1) ? $clog2(DM_CELDAS) : 1;

    localparam logic [OPCODE-1:0] OP_HLT  = OPCODE'(0);
    localparam logic [OPCODE-1:0] OP_STO  = OPCODE'(1);
    localparam logic [OPCODE-1:0] OP_LD   = OPCODE'(2);
    localparam logic [OPCODE-1:0] OP_LDI  = OPCODE'(3);
    localparam logic [OPCODE-1:0] OP_ADD  = OPCODE'(4);
    localparam logic [OPCODE-1:0] OP_ADDI = OPCODE'(5);
    localparam logic [OPCODE-1:0] OP_SUB  = OPCODE'(6);
    localparam logic [OPCODE-1:0] OP_SUBI = OPCODE'(7);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Memories are not reset: contents survive i_reset
    logic [NBITS_D-1:0]   r_pm [PM_CELDAS];
    logic [NBITS_D-1:0]   r_dm [DM_CELDAS];

    state_t               r_state;
    state_t               w_state_next;
    logic [NBITS_O-1:0]   r_pc;
    logic [NBITS_O-1:0]   w_pc_next;
    logic [NBITS_D-1:0]   r_acc;
    logic [NBITS_D-1:0]   w_acc_next;
    logic [NBITS_CNT-1:0] r_cycles;
    logic [NBITS_CNT-1:0] w_cycles_next;
    logic                 r_enable;
    logic                 r_halt;

    logic [NBITS_D-1:0]   w_instr;
    logic [OPCODE-1:0]    w_opcode;
    logic [NBITS_O-1:0]   w_operand;
    logic [NBITS_D-1:0]   w_imm;
    logic [NBITS_D-1:0]   w_dm_rd;
    logic [NBITS_O-1:0]   w_pc_inc;
    logic                 w_pc_valid;
    logic                 w_op_valid;
    logic                 w_load_valid;
    logic                 w_exec;
    logic                 w_pm_we;
    logic                 w_dm_we;

    // Fetch, decode and operand read (asynchronous memory reads)
    always_comb begin
        w_pc_valid   = (32'(r_pc) < PM_CELDAS);
        w_instr      = w_pc_valid ? r_pm[r_pc[PM_AW-1:0]] : '0;
        w_opcode     = w_instr[NBITS_D-1 -: OPCODE];
        w_operand    = w_instr[NBITS_O-1:0];
        w_imm        = NBITS_D'($signed(w_operand));
        w_op_valid   = (32'(w_operand) < DM_CELDAS);
        w_dm_rd      = w_op_valid ? r_dm[w_operand[DM_AW-1:0]] : '0;
        w_load_valid = (32'(bus.i_load_addr) < PM_CELDAS);
        w_pc_inc     = (32'(r_pc) == PM_CELDAS - 1) ? '0 : r_pc + NBITS_O'(1);
        w_exec       = (r_state == ST_RUN) && (!bus.i_mode || bus.i_step);
    end

    // Next-state, datapath and memory write-enable logic
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_acc_next    = r_acc;
        w_cycles_next = r_cycles;
        w_pm_we       = 1'b0;
        w_dm_we       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_load_en) begin
                    w_pm_we = w_load_valid;
                end else if (bus.i_start) begin
                    w_state_next = ST_RUN;
                    w_pc_next    = '0;
                end
            end
            ST_RUN: begin
                if (w_exec) begin
                    if (r_cycles != '1) begin
                        w_cycles_next = r_cycles + NBITS_CNT'(1);
                    end
                    w_pc_next = w_pc_inc;
                    case (w_opcode)
                        OP_HLT: begin
                            w_state_next = ST_HALT;
                            w_pc_next    = r_pc;
                        end
                        OP_STO:  w_dm_we    = w_op_valid;
                        OP_LD:   w_acc_next = w_dm_rd;
                        OP_LDI:  w_acc_next = w_imm;
                        OP_ADD:  w_acc_next = r_acc + w_dm_rd;
                        OP_ADDI: w_acc_next = r_acc + w_imm;
                        OP_SUB:  w_acc_next = r_acc - w_dm_rd;
                        OP_SUBI: w_acc_next = r_acc - w_imm;
                        default: ;
                    endcase
                end
            end
            ST_HALT: ;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State and architectural registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_acc    <= '0;
            r_cycles <= '0;
            r_enable <= 1'b0;
            r_halt   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_acc    <= w_acc_next;
            r_cycles <= w_cycles_next;
            r_enable <= (w_state_next == ST_RUN);
            r_halt   <= (w_state_next == ST_HALT);
        end
    end

    // Program memory load port; a reset edge suppresses the write
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_pm_we) begin
            r_pm[bus.i_load_addr[PM_AW-1:0]] <= bus.i_load_data;
        end
    end

    // Data memory store; an STO coinciding with reset is dropped
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_dm_we) begin
            r_dm[w_operand[DM_AW-1:0]] <= r_acc;
        end
    end

    assign bus.o_pc     = r_pc;
    assign bus.o_acc    = r_acc;
    assign bus.o_cycles = r_cycles;
    assign bus.o_enable = r_enable;
    assign bus.o_halt   = r_halt;
endmodule

// File: tb/tb_bip_system.sv
// Self-checking bench for bip_system: a per-edge instruction-level model of
// two instances (default depths and a 4-word program memory) checked every
// cycle, plus hand-computed end results for each directed program.
module tb_bip_system;
    logic clk;
    logic rst;

    bip_system_if #(.NBITS_O(11), .NBITS_D(16), .NBITS_CNT(32)) b0 ();
    bip_system_if #(.NBITS_O(11), .NBITS_D(16), .NBITS_CNT(32)) b1 ();

    bip_system u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (b0.slave)
    );

    bip_system #(.PM_CELDAS(4)) u_dut4 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Instruction-level model state, index 0 = default instance, 1 = PM depth 4
    int unsigned pm_depth [2] = '{512, 4};
    int unsigned dm_depth [2] = '{512, 512};
    logic [15:0] m_pm  [2][512];
    logic [15:0] m_dm  [2][512];
    logic [10:0] m_pc  [2];
    logic [15:0] m_acc [2];
    logic [31:0] m_cyc [2];
    int          m_st  [2];   // 0 idle, 1 run, 2 halt

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int opr);
        logic [4:0]  o;
        logic [10:0] a;
        o = 5'(op);
        a = 11'(opr);
        return {o, a};
    endfunction

    // One clock edge of the architectural behaviour
    task automatic model_edge(input int k, input bit r, input bit ld, input logic [10:0] la,
                              input logic [15:0] ldd, input bit st, input bit md, input bit stp);
        logic [15:0] ins, imm, mem;
        logic [4:0]  op;
        logic [10:0] opr;
        if (r) begin
            m_st[k] = 0; m_pc[k] = '0; m_acc[k] = '0; m_cyc[k] = '0;
            return;
        end
        if (m_st[k] == 0) begin
            if (ld) begin
                if (int'(la) < int'(pm_depth[k])) m_pm[k][la] = ldd;
            end else if (st) begin
                m_st[k] = 1;
            end
        end else if (m_st[k] == 1 && (!md || stp)) begin
            ins = (int'(m_pc[k]) < int'(pm_depth[k])) ? m_pm[k][m_pc[k]] : 16'h0;
            op  = ins[15:11];
            opr = ins[10:0];
            imm = {{5{opr[10]}}, opr};
            mem = (int'(opr) < int'(dm_depth[k])) ? m_dm[k][opr] : 16'h0;
            if (m_cyc[k] != 32'hFFFF_FFFF) m_cyc[k] = m_cyc[k] + 1;
            if (op == 0) begin
                m_st[k] = 2;
            end else begin
                case (op)
                    1: if (int'(opr) < int'(dm_depth[k])) m_dm[k][opr] = m_acc[k];
                    2: m_acc[k] = mem;
                    3: m_acc[k] = imm;
                    4: m_acc[k] = m_acc[k] + mem;
                    5: m_acc[k] = m_acc[k] + imm;
                    6: m_acc[k] = m_acc[k] - mem;
                    7: m_acc[k] = m_acc[k] - imm;
                    default: ;
                endcase
                m_pc[k] = (int'(m_pc[k]) == int'(pm_depth[k]) - 1) ? 11'd0 : m_pc[k] + 11'd1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_edge(0, rst, b0.i_load_en, b0.i_load_addr, b0.i_load_data, b0.i_start, b0.i_mode, b0.i_step);
        model_edge(1, rst, b1.i_load_en, b1.i_load_addr, b1.i_load_data, b1.i_start, b1.i_mode, b1.i_step);
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc0",     64'(b0.o_pc),     64'(m_pc[0]));
            chk("acc0",    64'(b0.o_acc),    64'(m_acc[0]));
            chk("cycles0", 64'(b0.o_cycles), 64'(m_cyc[0]));
            chk("enable0", 64'(b0.o_enable), 64'(m_st[0] == 1));
            chk("halt0",   64'(b0.o_halt),   64'(m_st[0] == 2));
            chk("pc1",     64'(b1.o_pc),     64'(m_pc[1]));
            chk("acc1",    64'(b1.o_acc),    64'(m_acc[1]));
            chk("cycles1", 64'(b1.o_cycles), 64'(m_cyc[1]));
            chk("enable1", 64'(b1.o_enable), 64'(m_st[1] == 1));
            chk("halt1",   64'(b1.o_halt),   64'(m_st[1] == 2));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load0(input int addr, input logic [15:0] data);
        b0.i_load_en   = 1'b1;
        b0.i_load_addr = 11'(addr);
        b0.i_load_data = data;
        @(negedge clk);
        b0.i_load_en   = 1'b0;
    endtask

    task automatic load_prog(input logic [15:0] p[$]);
        foreach (p[i]) load0(i, p[i]);
    endtask

    task automatic start0();
        b0.i_start = 1'b1;
        @(negedge clk);
        b0.i_start = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n;
        n = 0;
        while (!b0.o_halt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_halt_reached"}, 64'(b0.o_halt), 64'd1);
    endtask

    logic [15:0] prog1 [$];
    logic [15:0] prog  [$];
    int          pcs   [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 512; i++) begin
                m_pm[k][i] = '0;
                m_dm[k][i] = '0;
            end
            m_pc[k] = '0; m_acc[k] = '0; m_cyc[k] = '0; m_st[k] = 0;
        end
        rst = 1'b1;
        b0.i_load_en = 1'b0; b0.i_load_addr = '0; b0.i_load_data = '0;
        b0.i_start = 1'b0; b0.i_mode = 1'b0; b0.i_step = 1'b0;
        b1.i_load_en = 1'b0; b1.i_load_addr = '0; b1.i_load_data = '0;
        b1.i_start = 1'b0; b1.i_mode = 1'b0; b1.i_step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_pc",     64'(b0.o_pc),     64'd0);
        chk("reset_cycles", 64'(b0.o_cycles), 64'd0);
        chk("reset_enable", 64'(b0.o_enable), 64'd0);

        // Basic program: LDI 5; ADDI -2; STO 3; LD 3; HLT
        prog1 = '{enc(3, 5), enc(5, -2), enc(1, 3), enc(2, 3), enc(0, 0)};
        load_prog(prog1);
        start0();
        chk("start_enable", 64'(b0.o_enable), 64'd1);
        wait_halt("p1", 20);
        chk("p1_acc",    64'(b0.o_acc),    64'd3);
        chk("p1_pc",     64'(b0.o_pc),     64'd4);
        chk("p1_cycles", 64'(b0.o_cycles), 64'd5);
        chk("p1_enable", 64'(b0.o_enable), 64'd0);

        // Reset after the 2nd instruction, restart without reloading
        do_reset();
        start0();
        @(negedge clk);
        @(negedge clk);
        chk("mid_acc",    64'(b0.o_acc),    64'd3);
        chk("mid_cycles", 64'(b0.o_cycles), 64'd2);
        do_reset();
        chk("abort_pc",   64'(b0.o_pc),     64'd0);
        chk("abort_en",   64'(b0.o_enable), 64'd0);
        start0();
        wait_halt("p1r", 20);
        chk("p1r_acc",    64'(b0.o_acc),    64'd3);
        chk("p1r_cycles", 64'(b0.o_cycles), 64'd5);
        chk("p1r_pc",     64'(b0.o_pc),     64'd4);

        // Build 0x7FFF in dm[0], then ADD 0 -> 0xFFFE; also leaves dm[3]=0xFFFE
        do_reset();
        prog = {};
        prog.push_back(enc(3, 'h3FF));
        for (int i = 0; i < 5; i++) begin
            prog.push_back(enc(1, 0));
            prog.push_back(enc(4, 0));
            prog.push_back(enc(5, 1));
        end
        prog.push_back(enc(1, 0));
        prog.push_back(enc(4, 0));
        prog.push_back(enc(1, 3));
        prog.push_back(enc(0, 0));
        load_prog(prog);
        start0();
        wait_halt("ovf", 40);
        chk("ovf_acc",    64'(b0.o_acc),    64'hFFFE);
        chk("ovf_cycles", 64'(b0.o_cycles), 64'd20);

        // SUBI 1 from zero wraps; SUB of dm[0]=0x7FFF follows in a second run
        do_reset();
        load_prog('{enc(3, 0), enc(7, 1), enc(0, 0)});
        start0();
        wait_halt("subi", 20);
        chk("subi_acc", 64'(b0.o_acc), 64'hFFFF);
        do_reset();
        load_prog('{enc(3, -1), enc(6, 0), enc(0, 0)});
        start0();
        wait_halt("sub", 20);
        chk("sub_acc", 64'(b0.o_acc), 64'h8000);

        // Load and start together: word written, stays IDLE; STO 600 ignored
        do_reset();
        b0.i_start = 1'b1;
        load0(0, enc(3, 7));
        b0.i_start = 1'b0;
        chk("ldstart_enable", 64'(b0.o_enable), 64'd0);
        load0(1, enc(1, 600));
        load0(2, enc(4, 600));
        load0(3, enc(0, 0));
        start0();
        wait_halt("oob_sto", 20);
        chk("oob_sto_acc", 64'(b0.o_acc), 64'd7);
        do_reset();
        load_prog('{enc(3, 9), enc(2, 600), enc(0, 0)});
        start0();
        wait_halt("oob_ld", 20);
        chk("oob_ld_acc", 64'(b0.o_acc), 64'd0);

        // Step mode with the basic program; a load during RUN is ignored
        do_reset();
        load_prog(prog1);
        b0.i_mode = 1'b1;
        start0();
        b0.i_start = 1'b1;
        load0(4, enc(3, 7));
        b0.i_start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            repeat (4) @(negedge clk);
            b0.i_step = 1'b1;
            @(negedge clk);
            b0.i_step = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("step_cycles", 64'(b0.o_cycles), 64'd3);
        chk("step_pc",     64'(b0.o_pc),     64'd3);
        chk("step_enable", 64'(b0.o_enable), 64'd1);
        b0.i_mode = 1'b0;
        wait_halt("step", 20);
        chk("step_acc",    64'(b0.o_acc),    64'd3);
        chk("step_fcyc",   64'(b0.o_cycles), 64'd5);
        chk("step_fpc",    64'(b0.o_pc),     64'd4);

        // PM depth 4, all NOPs: PC wraps 3 -> 0; load beyond depth ignored
        do_reset();
        for (int a = 0; a < 4; a++) begin
            b1.i_load_en = 1'b1; b1.i_load_addr = 11'(a); b1.i_load_data = 16'h4000;
            @(negedge clk);
        end
        b1.i_load_addr = 11'd4; b1.i_load_data = 16'h0000;
        @(negedge clk);
        b1.i_load_en = 1'b0;
        b1.i_start = 1'b1;
        @(negedge clk);
        b1.i_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("wrap_pc%0d", i), 64'(b1.o_pc), 64'(pcs[i]));
            @(negedge clk);
        end
        chk("wrap_cycles", 64'(b1.o_cycles), 64'd6);
        chk("wrap_enable", 64'(b1.o_enable), 64'd1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
